// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - data-memory access controller between the M stage and a valid/ready memory bus
module data_mem_ctrl (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] alu_result_m_i,
    input  logic [31:0] write_data_m_i,
    input  logic [2:0]  width_src_m_i,
    input  logic        mem_read_m_i,
    input  logic        mem_write_m_i,
    input  logic        stall_m_i,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic [31:0] req_addr_o,
    output logic        req_we_o,
    output logic [3:0]  req_wstrb_o,
    output logic [31:0] req_wdata_o,
    input  logic        rsp_valid_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] read_data_m_o,
    output logic        mem_stall_o,
    output logic        misaligned_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        access;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        start;
    logic [3:0]  wstrb_enc;
    logic [31:0] wdata_enc;

    logic [31:0] addr_q;
    logic [1:0]  offset_q;
    logic        we_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    // Load signedness is applied downstream; this block only needs the size.
    logic        unused_signedness;
    assign unused_signedness = width_src_m_i[2];

    assign access  = mem_read_m_i | mem_write_m_i;
    assign is_byte = (width_src_m_i[1:0] == 2'b10);
    assign is_half = (width_src_m_i[1:0] == 2'b01);
    assign is_word = !is_byte && !is_half;

    assign misaligned = (is_half && alu_result_m_i[0]) ||
                        (is_word && (alu_result_m_i[1:0] != 2'b00));

    assign start = (state_q == S_IDLE) && access && !misaligned;

    // Store data is replicated across lanes so the strobes alone select the target bytes.
    always_comb begin
        wstrb_enc = 4'b1111;
        wdata_enc = write_data_m_i;
        if (is_byte) begin
            wstrb_enc = 4'b0001 << alu_result_m_i[1:0];
            wdata_enc = {4{write_data_m_i[7:0]}};
        end else if (is_half) begin
            wstrb_enc = 4'b0011 << {alu_result_m_i[1], 1'b0};
            wdata_enc = {2{write_data_m_i[15:0]}};
        end
        if (!mem_write_m_i) begin
            wstrb_enc = 4'b0000;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (req_ready_i) begin
                    state_d = we_q ? S_DONE : S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_valid_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Holding here while M is stalled keeps the same instruction from issuing twice.
                if (!stall_m_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_valid_o  = (state_q == S_REQ);
        mem_stall_o  = start || (state_q == S_REQ) || (state_q == S_RESP);
        misaligned_o = (state_q == S_IDLE) && access && misaligned;
    end

    // Request fields are captured once on entry to REQ and stay stable until acceptance.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            addr_q   <= '0;
            offset_q <= '0;
            we_q     <= 1'b0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (start) begin
                addr_q   <= {alu_result_m_i[31:2], 2'b00};
                offset_q <= alu_result_m_i[1:0];
                we_q     <= mem_write_m_i;
                wstrb_q  <= wstrb_enc;
                wdata_q  <= wdata_enc;
            end
            if ((state_q == S_RESP) && rsp_valid_i) begin
                rdata_q <= rsp_rdata_i >> {offset_q, 3'b000};
            end
        end
    end

    assign req_addr_o    = addr_q;
    assign req_we_o      = we_q;
    assign req_wstrb_o   = wstrb_q;
    assign req_wdata_o   = wdata_q;
    assign read_data_m_o = rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl with directed vectors and random accesses
module tb_data_mem_ctrl;

    logic        clk_i;
    logic        reset_i;
    logic [31:0] alu_result_m_i;
    logic [31:0] write_data_m_i;
    logic [2:0]  width_src_m_i;
    logic        mem_read_m_i;
    logic        mem_write_m_i;
    logic        stall_m_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] req_addr_o;
    logic        req_we_o;
    logic [3:0]  req_wstrb_o;
    logic [31:0] req_wdata_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_rdata_i;
    logic [31:0] read_data_m_o;
    logic        mem_stall_o;
    logic        misaligned_o;

    data_mem_ctrl dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .alu_result_m_i (alu_result_m_i),
        .write_data_m_i (write_data_m_i),
        .width_src_m_i  (width_src_m_i),
        .mem_read_m_i   (mem_read_m_i),
        .mem_write_m_i  (mem_write_m_i),
        .stall_m_i      (stall_m_i),
        .req_valid_o    (req_valid_o),
        .req_ready_i    (req_ready_i),
        .req_addr_o     (req_addr_o),
        .req_we_o       (req_we_o),
        .req_wstrb_o    (req_wstrb_o),
        .req_wdata_o    (req_wdata_o),
        .rsp_valid_i    (rsp_valid_i),
        .rsp_rdata_i    (rsp_rdata_i),
        .read_data_m_o  (read_data_m_o),
        .mem_stall_o    (mem_stall_o),
        .misaligned_o   (misaligned_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  width;
        logic        rd;
        logic        wr;
        int          rdy_dly;
        int          rsp_dly;
        int          hold;
        logic [31:0] rdata;
        logic        exp_mis;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
    } acc_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd = '0;
    acc_t        vec[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [1:0] w);
        case (w)
            2'b10:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic model_mis(input logic [31:0] addr, input logic [1:0] w);
        return (int'(addr[1:0]) % size_of(w)) != 0;
    endfunction

    function automatic logic [3:0] model_strb(input logic [31:0] addr, input logic [1:0] w,
                                              input logic write);
        logic [3:0] s;
        int off;
        s = '0;
        off = int'(addr[1:0]);
        if (write) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + size_of(w)) s[i] = 1'b1;
            end
        end
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = wd[8*(i % size_of(w)) +: 8];
        end
        return r;
    endfunction

    task automatic idle_cycle();
        mem_read_m_i  = 1'b0;
        mem_write_m_i = 1'b0;
        stall_m_i     = 1'b0;
        req_ready_i   = 1'($urandom_range(0, 1));
        rsp_valid_i   = 1'($urandom_range(0, 1));
        rsp_rdata_i   = $urandom;
        @(negedge clk_i);
        chk("idle_stall", 32'(mem_stall_o), 32'd0);
        chk("idle_req_valid", 32'(req_valid_o), 32'd0);
        chk("idle_rdata_hold", read_data_m_o, last_rd);
        @(posedge clk_i); #1;
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
    endtask

    // Entered one step after a rising edge with the controller expected to be idle.
    task automatic run_access(input acc_t v);
        logic is_load;
        int   stalls;
        is_load = v.rd && !v.wr;
        stalls  = 0;
        alu_result_m_i = v.addr;
        write_data_m_i = v.wd;
        width_src_m_i  = v.width;
        mem_read_m_i   = v.rd;
        mem_write_m_i  = v.wr;
        stall_m_i      = 1'b0;
        req_ready_i    = 1'b0;
        rsp_valid_i    = 1'b0;
        @(negedge clk_i);
        chk("misaligned", 32'(misaligned_o), 32'(v.exp_mis));
        chk("first_req_valid", 32'(req_valid_o), 32'd0);
        if (v.exp_mis) begin
            chk("mis_stall", 32'(mem_stall_o), 32'd0);
            @(posedge clk_i); #1;
            mem_read_m_i  = 1'b0;
            mem_write_m_i = 1'b0;
            @(negedge clk_i);
            chk("mis_no_req", 32'(req_valid_o), 32'd0);
            chk("mis_no_stall", 32'(mem_stall_o), 32'd0);
            chk("mis_rdata_hold", read_data_m_o, last_rd);
            @(posedge clk_i); #1;
            return;
        end
        if (mem_stall_o) stalls++;
        @(posedge clk_i); #1;
        for (int k = 0; k <= v.rdy_dly; k++) begin
            req_ready_i = (k == v.rdy_dly);
            rsp_valid_i = 1'($urandom_range(0, 1));
            rsp_rdata_i = $urandom;
            @(negedge clk_i);
            chk("req_valid", 32'(req_valid_o), 32'd1);
            chk("req_addr", req_addr_o, v.addr & 32'hFFFF_FFFC);
            chk("req_we", 32'(req_we_o), 32'(v.wr));
            chk("req_wstrb", 32'(req_wstrb_o), 32'(v.exp_strb));
            if (!is_load) chk("req_wdata", req_wdata_o, v.exp_wdata);
            if (mem_stall_o) stalls++;
            @(posedge clk_i); #1;
        end
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        if (is_load) begin
            for (int k = 0; k <= v.rsp_dly; k++) begin
                req_ready_i = 1'($urandom_range(0, 1));
                rsp_valid_i = (k == v.rsp_dly);
                rsp_rdata_i = (k == v.rsp_dly) ? v.rdata : $urandom;
                @(negedge clk_i);
                chk("resp_req_valid", 32'(req_valid_o), 32'd0);
                if (mem_stall_o) stalls++;
                @(posedge clk_i); #1;
            end
            last_rd = v.exp_rd;
        end
        chk("stall_cycles", 32'(stalls), 32'(2 + v.rdy_dly + (is_load ? v.rsp_dly + 1 : 0)));
        for (int k = 0; k <= v.hold; k++) begin
            stall_m_i   = (k < v.hold);
            req_ready_i = 1'($urandom_range(0, 1));
            rsp_valid_i = 1'($urandom_range(0, 1));
            rsp_rdata_i = $urandom;
            @(negedge clk_i);
            chk("done_stall", 32'(mem_stall_o), 32'd0);
            chk("done_req_valid", 32'(req_valid_o), 32'd0);
            chk("done_rdata", read_data_m_o, last_rd);
            @(posedge clk_i); #1;
        end
        stall_m_i   = 1'b0;
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
    endtask

    initial begin
        acc_t r;
        reset_i        = 1'b0;
        alu_result_m_i = '0;
        write_data_m_i = '0;
        width_src_m_i  = '0;
        mem_read_m_i   = 1'b0;
        mem_write_m_i  = 1'b0;
        stall_m_i      = 1'b0;
        req_ready_i    = 1'b0;
        rsp_valid_i    = 1'b0;
        rsp_rdata_i    = '0;

        //          addr          wd            wid     rd wr rdy rsp hld rdata         mis strb     wdata         rd_exp
        vec[0]  = '{32'h100,      32'h0,        3'b000, 1, 0, 0,  0,  0,  32'hDEADBEEF, 0,  4'b0000, 32'h0,        32'hDEADBEEF};
        vec[1]  = '{32'h203,      32'h000000A5, 3'b010, 0, 1, 0,  0,  0,  32'h0,        0,  4'b1000, 32'hA5A5A5A5, 32'h0};
        vec[2]  = '{32'h302,      32'h0,        3'b001, 1, 0, 0,  0,  0,  32'h1234ABCD, 0,  4'b0000, 32'h0,        32'h00001234};
        vec[3]  = '{32'h10,       32'h0000BEEF, 3'b001, 0, 1, 4,  0,  0,  32'h0,        0,  4'b0011, 32'hBEEFBEEF, 32'h0};
        vec[4]  = '{32'h101,      32'h0,        3'b000, 1, 0, 0,  0,  0,  32'h0,        1,  4'b0000, 32'h0,        32'h0};
        vec[5]  = '{32'h7,        32'h0,        3'b110, 1, 0, 0,  0,  2,  32'h80FF0000, 0,  4'b0000, 32'h0,        32'h00000080};
        vec[6]  = '{32'h22,       32'h12345678, 3'b001, 0, 1, 1,  0,  0,  32'h0,        0,  4'b1100, 32'h56785678, 32'h0};
        vec[7]  = '{32'h33,       32'h0,        3'b001, 0, 1, 0,  0,  0,  32'h0,        1,  4'b0000, 32'h0,        32'h0};
        vec[8]  = '{32'h40,       32'hCAFEF00D, 3'b011, 0, 1, 0,  0,  1,  32'h0,        0,  4'b1111, 32'hCAFEF00D, 32'h0};
        vec[9]  = '{32'h42,       32'h0,        3'b011, 1, 0, 0,  0,  0,  32'h0,        1,  4'b0000, 32'h0,        32'h0};
        vec[10] = '{32'h51,       32'h0000003C, 3'b010, 1, 1, 0,  0,  0,  32'h0,        0,  4'b0010, 32'h3C3C3C3C, 32'h0};
        vec[11] = '{32'hFFC,      32'h0,        3'b000, 1, 0, 2,  3,  0,  32'h0BADF00D, 0,  4'b0000, 32'h0,        32'h0BADF00D};
        vec[12] = '{32'h1,        32'h0,        3'b010, 1, 0, 0,  1,  0,  32'h11223344, 0,  4'b0000, 32'h0,        32'h00112233};

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_req_valid", 32'(req_valid_o), 32'd0);
        chk("rst_req_we", 32'(req_we_o), 32'd0);
        chk("rst_req_wstrb", 32'(req_wstrb_o), 32'd0);
        chk("rst_req_addr", req_addr_o, 32'd0);
        chk("rst_req_wdata", req_wdata_o, 32'd0);
        chk("rst_read_data", read_data_m_o, 32'd0);
        chk("rst_stall", 32'(mem_stall_o), 32'd0);
        chk("rst_misaligned", 32'(misaligned_o), 32'd0);
        @(posedge clk_i); #1;
        reset_i = 1'b1;

        foreach (vec[i]) run_access(vec[i]);
        idle_cycle();

        // Reset while waiting for a read response, then a stray response afterwards.
        alu_result_m_i = 32'h200;
        width_src_m_i  = 3'b000;
        mem_read_m_i   = 1'b1;
        @(negedge clk_i);
        chk("rr_idle_stall", 32'(mem_stall_o), 32'd1);
        @(posedge clk_i); #1;
        req_ready_i = 1'b1;
        @(negedge clk_i);
        chk("rr_req_valid", 32'(req_valid_o), 32'd1);
        @(posedge clk_i); #1;
        req_ready_i = 1'b0;
        @(negedge clk_i);
        chk("rr_resp_stall", 32'(mem_stall_o), 32'd1);
        @(posedge clk_i); #1;
        reset_i      = 1'b0;
        mem_read_m_i = 1'b0;
        #1;
        chk("rr_req_valid_drop", 32'(req_valid_o), 32'd0);
        chk("rr_stall_drop", 32'(mem_stall_o), 32'd0);
        chk("rr_read_data_clr", read_data_m_o, 32'd0);
        last_rd = '0;
        @(posedge clk_i); #1;
        reset_i     = 1'b1;
        rsp_valid_i = 1'b1;
        rsp_rdata_i = 32'hFFFFFFFF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            chk("rr_stray_req_valid", 32'(req_valid_o), 32'd0);
            chk("rr_stray_stall", 32'(mem_stall_o), 32'd0);
            chk("rr_stray_ignored", read_data_m_o, 32'd0);
            @(posedge clk_i); #1;
        end
        rsp_valid_i = 1'b0;
        r = '{32'h201, 32'h0, 3'b010, 1, 0, 0, 0, 0, 32'h00AB0000, 0, 4'b0000, 32'h0, 32'h0000AB00};
        run_access(r);

        for (int n = 0; n < 150; n++) begin
            int op;
            r.addr  = $urandom;
            r.wd    = $urandom;
            r.width = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                r.addr = r.addr & ~32'(size_of(r.width[1:0]) - 1);
            op = $urandom_range(0, 2);
            r.rd        = (op != 1);
            r.wr        = (op != 0);
            r.rdy_dly   = $urandom_range(0, 3);
            r.rsp_dly   = $urandom_range(0, 3);
            r.hold      = $urandom_range(0, 2);
            r.rdata     = $urandom;
            r.exp_mis   = model_mis(r.addr, r.width[1:0]);
            r.exp_strb  = model_strb(r.addr, r.width[1:0], r.wr);
            r.exp_wdata = model_wdata(r.wd, r.width[1:0]);
            r.exp_rd    = r.rdata >> (8 * int'(r.addr[1:0]));
            run_access(r);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
